// File: rtl/mul_pkg.sv
// Shared definitions for the round-robin multiplier scheduler.
package mul_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_NREQ  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_rr_sched_if.sv
// Requester-facing bus of the shared multiplier: requests, operands, grant and result.
interface mul_rr_sched_if
    import mul_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [2*WIDTH-1:0]    product;
    logic                  busy;

    modport master (
        output req, a_in, b_in,
        input  gnt, done, product, busy
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, done, product, busy
    );

endinterface

// File: rtl/shift_add_core.sv
// Unsigned shift-add multiplier: loads on start, then runs exactly WIDTH steps.
module shift_add_core
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done_c,
    output logic [2*WIDTH-1:0] acc
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic             last_c;

    // cnt counts 0..WIDTH-1, so the last step is the one where it reads WIDTH-1
    assign last_c = run_q && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start) begin
            mcand_q  <= PW'(a);
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (last_c) begin
                run_q <= 1'b0;
            end
        end
    end

    assign busy   = run_q;
    assign done_c = last_c;
    assign acc    = acc_q;

endmodule

// File: rtl/mul_rr_sched.sv
// Round-robin arbiter sharing one shift_add_core among NREQ requesters.
module mul_rr_sched
    import mul_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic          CLK,
    input  logic          RST_N,
    mul_rr_sched_if.slave bus
);

    localparam int unsigned PW = $clog2(NREQ);

    state_e             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      gnt_idx_q, gnt_idx_d;
    logic [PW-1:0]      win_idx_c;
    logic [PW-1:0]      cand_c;
    logic               win_vld_c;
    logic               start_c;
    logic [WIDTH-1:0]   a_arr [NREQ];
    logic [WIDTH-1:0]   b_arr [NREQ];
    logic [WIDTH-1:0]   a_sel_c, b_sel_c;
    logic               core_busy;
    logic               core_done_c;
    logic [2*WIDTH-1:0] core_acc;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = bus.a_in[g*WIDTH +: WIDTH];
        assign b_arr[g] = bus.b_in[g*WIDTH +: WIDTH];
    end

    // First set request searching ptr+1, ptr+2, ... modulo NREQ
    always_comb begin
        win_vld_c = 1'b0;
        win_idx_c = '0;
        cand_c    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_c = PW'((32'(ptr_q) + k) % NREQ);
            if (!win_vld_c && bus.req[cand_c]) begin
                win_vld_c = 1'b1;
                win_idx_c = cand_c;
            end
        end
    end

    assign a_sel_c = a_arr[win_idx_c];
    assign b_sel_c = b_arr[win_idx_c];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            ptr_q     <= PW'(NREQ - 1);
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        start_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld_c) begin
                    start_c   = 1'b1;
                    gnt_d     = NREQ'(1) << win_idx_c;
                    gnt_idx_d = win_idx_c;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_busy && core_done_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Moving the pointer to the winner hands priority to the next index
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = gnt_idx_q;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .start  (start_c),
        .a      (a_sel_c),
        .b      (b_sel_c),
        .busy   (core_busy),
        .done_c (core_done_c),
        .acc    (core_acc)
    );

    // Accumulator is only cleared at the next grant, so product holds through IDLE
    assign bus.gnt     = gnt_q;
    assign bus.done    = (state_q == ST_DONE) ? gnt_q : '0;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.product = core_acc;

endmodule

// File: tb/tb_mul_rr_sched.sv
// Directed bench for mul_rr_sched: reset, latency, extremes, contention, fairness, mid-op changes.
module tb_mul_rr_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [WIDTH-1:0] a_v [NREQ];
    logic [WIDTH-1:0] b_v [NREQ];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    mul_rr_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign bus.a_in[g*WIDTH +: WIDTH] = a_v[g];
        assign bus.b_in[g*WIDTH +: WIDTH] = b_v[g];
    end

    mul_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N   = 1'b0;
        bus.req = '0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N   = 1'b0;
        bus.req = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", bus.done); end
        checks++; if (bus.product !== 16'd0) begin errors++; $display("FAIL reset_product: got %0d want 0", bus.product); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_single(input logic [1:0] idx, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] exp);
        logic [3:0] oh;
        int n;
        oh = 4'b0001 << idx;
        @(negedge CLK);
        a_v[idx] = a;
        b_v[idx] = b;
        bus.req  = oh;
        step();
        checks++; if (bus.gnt !== oh) begin errors++; $display("FAIL single_gnt(%0d*%0d): got %b want %b", a, b, bus.gnt, oh); end
        n = 0;
        while (bus.done === 4'b0000 && n < 20) begin
            step();
            n++;
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL single_latency(%0d*%0d): got %0d want 8", a, b, n); end
        checks++; if (bus.done !== oh) begin errors++; $display("FAIL single_done(%0d*%0d): got %b want %b", a, b, bus.done, oh); end
        checks++; if (bus.product !== exp) begin errors++; $display("FAIL single_product(%0d*%0d): got %0d want %0d", a, b, bus.product, exp); end
        @(negedge CLK);
        bus.req = '0;
        step();
        checks++; if (bus.done !== 4'b0000 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
            errors++; $display("FAIL single_pulse_end: done=%b busy=%b gnt=%b want 0000/0/0000", bus.done, bus.busy, bus.gnt);
        end
        checks++; if (bus.product !== exp) begin errors++; $display("FAIL single_hold: got %0d want %0d", bus.product, exp); end
    endtask

    task automatic test_contention();
        logic [1:0]  order [5];
        logic [15:0] prods [5];
        int n;
        int last;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        prods = '{16'd15, 16'd63, 16'd144, 16'd200, 16'd15};
        last  = 0;
        do_reset();
        a_v[0] = 8'd3;   b_v[0] = 8'd5;
        a_v[1] = 8'd7;   b_v[1] = 8'd9;
        a_v[2] = 8'd12;  b_v[2] = 8'd12;
        a_v[3] = 8'd100; b_v[3] = 8'd2;
        @(negedge CLK);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (bus.gnt === 4'b0000 && n < 30) begin
                step();
                n++;
            end
            checks++; if (bus.gnt !== (4'b0001 << order[k])) begin
                errors++; $display("FAIL contention_gnt[%0d]: got %b want %b", k, bus.gnt, 4'b0001 << order[k]);
            end
            if (k > 0) begin
                checks++; if (cyc - last !== 10) begin errors++; $display("FAIL contention_gap[%0d]: got %0d want 10", k, cyc - last); end
            end
            last = cyc;
            n = 0;
            while (bus.done === 4'b0000 && n < 20) begin
                step();
                n++;
            end
            checks++; if (bus.product !== prods[k]) begin
                errors++; $display("FAIL contention_product[%0d]: got %0d want %0d", k, bus.product, prods[k]);
            end
            if (k == 4) begin
                @(negedge CLK);
                bus.req = '0;
            end
            step();
        end
    endtask

    task automatic test_fairness();
        int n;
        @(negedge CLK);
        a_v[1] = 8'd4; b_v[1] = 8'd4;
        a_v[2] = 8'd5; b_v[2] = 8'd5;
        bus.req = 4'b0010;
        step();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL fair_first_gnt: got %b want 0010", bus.gnt); end
        step();
        @(negedge CLK);
        bus.req = 4'b0110;
        n = 0;
        while (bus.done === 4'b0000 && n < 20) begin
            step();
            n++;
        end
        checks++; if (bus.product !== 16'd16) begin errors++; $display("FAIL fair_first_product: got %0d want 16", bus.product); end
        step();
        step();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL fair_next_gnt: got %b want 0100", bus.gnt); end
        @(negedge CLK);
        bus.req = '0;
        n = 0;
        while (bus.done === 4'b0000 && n < 20) begin
            step();
            n++;
        end
        checks++; if (bus.product !== 16'd25) begin errors++; $display("FAIL fair_second_product: got %0d want 25", bus.product); end
        step();
    endtask

    task automatic test_midop();
        int n;
        @(negedge CLK);
        a_v[3] = 8'd20; b_v[3] = 8'd6;
        bus.req = 4'b1000;
        step();
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL midop_gnt: got %b want 1000", bus.gnt); end
        @(negedge CLK);
        bus.req = '0;
        a_v[3] = 8'd255; b_v[3] = 8'd255;
        n = 0;
        while (bus.done === 4'b0000 && n < 20) begin
            step();
            n++;
        end
        checks++; if (bus.done !== 4'b1000) begin errors++; $display("FAIL midop_done: got %b want 1000", bus.done); end
        checks++; if (bus.product !== 16'd120) begin errors++; $display("FAIL midop_product: got %0d want 120", bus.product); end
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midop_idle: busy=%b want 0", bus.busy); end
    endtask

    task automatic test_reset_midrun();
        @(negedge CLK);
        a_v[0] = 8'd9; b_v[0] = 8'd9;
        bus.req = 4'b0001;
        step();
        repeat (3) step();
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 4'b0000) begin
            errors++; $display("FAIL async_reset_ctrl: gnt=%b busy=%b done=%b want 0000/0/0000", bus.gnt, bus.busy, bus.done);
        end
        checks++; if (bus.product !== 16'd0) begin errors++; $display("FAIL async_reset_product: got %0d want 0", bus.product); end
        bus.req = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        test_single(2'd0, 8'd6, 8'd7, 16'd42);
    endtask

    initial begin
        test_reset();
        test_single(2'd0, 8'd13, 8'd11, 16'd143);
        test_single(2'd0, 8'd255, 8'd255, 16'd65025);
        test_single(2'd2, 8'd0, 8'd200, 16'd0);
        test_contention();
        test_fairness();
        test_midop();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
